// File: rtl/spi_slave.sv
// SPI mode-0 target: oversamples SCLK/SSbar/MOSI on clk, returns a preloaded byte on MISO
// while assembling the incoming MOSI byte into RDATA.
module spi_slave #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  apb_ready,
    input  logic [DATA_WIDTH-1:0] WDATA,
    output logic                  SPI_status_RDY_BSYbar,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic                  rx_data_valid,
    output logic                  tx_underrun,
    input  logic                  SCLK,
    input  logic                  SSbar,
    input  logic                  MOSI,
    output logic                  MISO,
    output logic                  MISO_oe
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
    logic                   sclk_d, ss_d;
    logic                   sclk_s, ss_s, mosi_s;
    logic                   sclk_rise, ss_fall, sel;
    logic [DATA_WIDTH-1:0]  hold_data, tx_shift, rx_next;
    logic [DATA_WIDTH-2:0]  rx_shift;
    logic                   hold_full, load_accept, last_bit;
    logic [CW-1:0]          bit_cnt;

    // SSbar synchronizer resets to "selected" so a frame already running when
    // reset releases never produces a fall; only a real high-then-low starts one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            ss_sync   <= '0;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            ss_d      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SSbar};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            ss_d      <= ss_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s      = sclk_sync[SYNC_STAGES-1];
    assign ss_s        = ss_sync[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise   = sclk_s & ~sclk_d;
    assign ss_fall     = ~ss_s & ss_d;
    assign sel         = ~ss_s;
    assign last_bit    = (bit_cnt == CW'(DATA_WIDTH - 1));
    assign load_accept = apb_ready & ~hold_full;
    assign rx_next     = {rx_shift, mosi_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ss_fall) state_nxt = LOAD;
            LOAD:    state_nxt = sel ? SHIFT : IDLE;
            SHIFT: begin
                if (!sel)                       state_nxt = IDLE;
                else if (sclk_rise && last_bit) state_nxt = LOAD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data     <= '0;
            hold_full     <= 1'b0;
            tx_shift      <= '0;
            rx_shift      <= '0;
            bit_cnt       <= '0;
            RDATA         <= '0;
            rx_data_valid <= 1'b0;
            tx_underrun   <= 1'b0;
        end else begin
            rx_data_valid <= 1'b0;
            tx_underrun   <= 1'b0;
            if (load_accept) hold_data <= WDATA;
            // Consume and accept are exclusive: accept needs empty, consume needs full.
            if (state == LOAD && hold_full) hold_full <= 1'b0;
            else if (load_accept)           hold_full <= 1'b1;
            case (state)
                LOAD: begin
                    bit_cnt <= '0;
                    if (hold_full) begin
                        tx_shift <= hold_data;
                    end else begin
                        tx_shift    <= '0;
                        tx_underrun <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (!sel) begin
                        bit_cnt <= '0;
                    end else if (sclk_rise) begin
                        rx_shift <= rx_next[DATA_WIDTH-2:0];
                        tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                        bit_cnt  <= bit_cnt + CW'(1);
                        if (last_bit) begin
                            RDATA         <= rx_next;
                            rx_data_valid <= 1'b1;
                        end
                    end
                end
                default: bit_cnt <= '0;
            endcase
        end
    end

    assign SPI_status_RDY_BSYbar = ~hold_full;
    assign MISO_oe               = (state != IDLE);
    assign MISO                  = (state != IDLE) ? tx_shift[DATA_WIDTH-1] : 1'b0;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a bit-banged mode-0 master at clk/4 plus a per-cycle
// monitor holding the expected receive sequence and output invariants.
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       rst_n, apb_ready, SCLK, SSbar, MOSI;
    logic [7:0] WDATA;
    logic       rdy, rx_data_valid, tx_underrun, MISO, MISO_oe;
    logic [7:0] RDATA;

    spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .apb_ready             (apb_ready),
        .WDATA                 (WDATA),
        .SPI_status_RDY_BSYbar (rdy),
        .RDATA                 (RDATA),
        .rx_data_valid         (rx_data_valid),
        .tx_underrun           (tx_underrun),
        .SCLK                  (SCLK),
        .SSbar                 (SSbar),
        .MOSI                  (MOSI),
        .MISO                  (MISO),
        .MISO_oe               (MISO_oe)
    );

    always #5 clk = ~clk;

    int         n_vec = 0, n_err = 0;
    int         valid_cnt = 0, underrun_cnt = 0;
    logic [7:0] model_rdata = 8'h00;
    logic [7:0] exp_rx[$];
    logic       prev_valid = 1'b0, prev_und = 1'b0;
    logic [7:0] got;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: RDATA only moves on a valid pulse and then to the next queued byte.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (rx_data_valid) begin
                valid_cnt++;
                chk("valid_single_cycle", {31'd0, prev_valid}, 0);
                if (exp_rx.size() == 0) begin
                    chk("valid_without_frame", {31'd0, rx_data_valid}, 0);
                end else begin
                    model_rdata = exp_rx.pop_front();
                    chk("rdata_on_valid", {24'd0, RDATA}, {24'd0, model_rdata});
                end
            end else begin
                chk("rdata_hold", {24'd0, RDATA}, {24'd0, model_rdata});
            end
            if (!MISO_oe) chk("miso_zero_deselected", {31'd0, MISO}, 0);
            if (tx_underrun) begin
                underrun_cnt++;
                chk("underrun_single_cycle", {31'd0, prev_und}, 0);
            end
            prev_valid = rx_data_valid;
            prev_und   = tx_underrun;
        end else begin
            prev_valid = 1'b0;
            prev_und   = 1'b0;
        end
    end

    // All tasks start and end on a falling clk edge.
    task automatic load(input logic [7:0] b);
        apb_ready = 1'b1;
        WDATA     = b;
        @(negedge clk);
        apb_ready = 1'b0;
    endtask

    task automatic ss_low();
        SSbar = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic ss_high();
        SSbar = 1'b1;
        repeat (8) @(negedge clk);
        chk("miso_oe_after_deselect", {31'd0, MISO_oe}, 0);
    endtask

    task automatic xfer(input logic [7:0] b, input int n, output logic [7:0] g);
        g = 8'h00;
        for (int i = 0; i < n; i++) begin
            MOSI = b[7-i];
            repeat (2) @(negedge clk);
            g[7-i] = MISO;
            SCLK = 1'b1;
            repeat (2) @(negedge clk);
            SCLK = 1'b0;
        end
    endtask

    task automatic do_byte(input logic [7:0] mosi_b, input logic [7:0] miso_exp, input string nm);
        logic [7:0] g;
        chk("miso_oe_selected", {31'd0, MISO_oe}, 1);
        exp_rx.push_back(mosi_b);
        xfer(mosi_b, 8, g);
        chk(nm, {24'd0, g}, {24'd0, miso_exp});
    endtask

    task automatic check_reset_outputs();
        chk("rst_miso", {31'd0, MISO}, 0);
        chk("rst_miso_oe", {31'd0, MISO_oe}, 0);
        chk("rst_rdata", {24'd0, RDATA}, 0);
        chk("rst_valid", {31'd0, rx_data_valid}, 0);
        chk("rst_underrun", {31'd0, tx_underrun}, 0);
        chk("rst_rdy", {31'd0, rdy}, 1);
    endtask

    initial begin
        logic [7:0] tail;
        rst_n = 1'b0; apb_ready = 1'b0; WDATA = 8'h00;
        SCLK = 1'b0; SSbar = 1'b1; MOSI = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Reset / first load
        load(8'h5A);
        chk("rdy_after_load", {31'd0, rdy}, 0);
        ss_low();
        chk("rdy_after_consume", {31'd0, rdy}, 1);
        do_byte(8'hC3, 8'h5A, "miso_5a");
        ss_high();
        chk("underrun_cnt_1", underrun_cnt, 1);

        // Single frame
        load(8'hAA);
        ss_low();
        chk("rdy_single", {31'd0, rdy}, 1);
        do_byte(8'h3C, 8'hAA, "miso_aa");
        ss_high();
        chk("rdata_3c", {24'd0, RDATA}, 32'h3C);
        chk("underrun_cnt_2", underrun_cnt, 2);

        // Continuous frames
        load(8'hA5);
        ss_low();
        load(8'h0F);
        chk("rdy_second_load", {31'd0, rdy}, 0);
        do_byte(8'h11, 8'hA5, "miso_a5");
        do_byte(8'h22, 8'h0F, "miso_0f");
        ss_high();
        chk("rdata_22", {24'd0, RDATA}, 32'h22);
        chk("valid_cnt_4", valid_cnt, 4);
        chk("underrun_cnt_3", underrun_cnt, 3);

        // Underrun and ignored load
        ss_low();
        chk("underrun_on_empty", underrun_cnt, 4);
        load(8'h77);
        chk("rdy_loaded_77", {31'd0, rdy}, 0);
        load(8'h99);
        chk("rdy_ignored_load", {31'd0, rdy}, 0);
        do_byte(8'h5E, 8'h00, "miso_underrun");
        do_byte(8'h81, 8'h77, "miso_77_kept");
        ss_high();
        chk("underrun_cnt_5", underrun_cnt, 5);

        // Abort after 5 bits
        load(8'hC6);
        ss_low();
        xfer(8'hF0, 5, got);
        chk("abort_partial_miso", {27'd0, got[7:3]}, 32'h18);
        ss_high();
        chk("abort_no_valid", valid_cnt, 6);
        chk("abort_rdata_kept", {24'd0, RDATA}, 32'h81);
        chk("rdy_after_abort", {31'd0, rdy}, 1);
        load(8'h3B);
        ss_low();
        do_byte(8'h96, 8'h3B, "miso_after_abort");
        ss_high();
        chk("underrun_cnt_6", underrun_cnt, 6);

        // Reset mid-frame
        load(8'h4D);
        ss_low();
        xfer(8'hE7, 3, got);
        chk("pre_reset_miso", {29'd0, got[7:5]}, 32'h2);
        #2 rst_n = 1'b0;
        model_rdata = 8'h00;
        #1 check_reset_outputs();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        tail = 8'hE7 << 3;
        xfer(tail, 5, got);
        chk("reset_tail_miso", {24'd0, got}, 0);
        chk("reset_tail_oe", {31'd0, MISO_oe}, 0);
        ss_high();
        chk("reset_no_valid", valid_cnt, 7);
        chk("reset_no_underrun", underrun_cnt, 6);
        load(8'h2C);
        ss_low();
        do_byte(8'h69, 8'h2C, "miso_after_reset");
        ss_high();
        chk("rdata_69", {24'd0, RDATA}, 32'h69);
        chk("valid_cnt_8", valid_cnt, 8);
        chk("underrun_cnt_7", underrun_cnt, 7);
        chk("rx_queue_drained", exp_rx.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI mode-0 (CPOL=0, CPHA=0) target that forms the far end of the link driven by `spi_master`. It receives MSB-first bytes on MOSI and simultaneously returns a pre-loaded byte on MISO. It oversamples SCLK, SSbar and MOSI on the system clock, so no logic runs in the SCLK domain. A one-entry transmit holding register and a byte-wide receive register face the same write/read bus style as the master (`apb_ready` strobe, `WDATA`, `RDATA`, `rx_data_valid`).

## Interface
- `DATA_WIDTH`, 8: frame length in bits; also the width of WDATA and RDATA.
- `SYNC_STAGES`, 2: synchronizer flops on SCLK, SSbar and MOSI; minimum value is 2.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `apb_ready`  in  1  load strobe; captures WDATA into the TX holding register when SPI_status_RDY_BSYbar=1.
- `WDATA`  in  DATA_WIDTH  byte to return on MISO in the next frame.
- `SPI_status_RDY_BSYbar`  out  1  1 = holding register empty, a load is accepted; 0 = full.
- `RDATA`  out  DATA_WIDTH  last complete byte received; held until the next complete byte.
- `rx_data_valid`  out  1  one-cycle pulse when RDATA updates.
- `tx_underrun`  out  1  one-cycle pulse when a frame starts with the holding register empty.
- `SCLK`  in  1  serial clock from the master; asynchronous to clk.
- `SSbar`  in  1  active-low select; asynchronous to clk.
- `MOSI`  in  1  master-to-slave data.
- `MISO`  out  1  slave-to-master data; driven 0 while deselected.
- `MISO_oe`  out  1  1 while selected; used for an external tri-state.

## Operation
- Reset values: MISO=0, MISO_oe=0, RDATA=0, rx_data_valid=0, tx_underrun=0, SPI_status_RDY_BSYbar=1. The holding register, shift registers and bit counter are cleared.
- Synchronization: SCLK, SSbar and MOSI each pass through SYNC_STAGES flops. One further register on SCLK and SSbar provides edge detection. `sel` is the synchronized version of ~SSbar.
- States:
  - IDLE (sel=0) → LOAD on a detected SSbar fall.
  - LOAD (one cycle) → SHIFT.
  - SHIFT → LOAD after the DATA_WIDTH-th rising edge while sel is still 1.
  - SHIFT → IDLE on a detected SSbar rise.
  - Any state → IDLE on rst_n low.
- LOAD:
  - If the holding register is full, the TX shift register takes its contents, the register is marked empty and RDY returns to 1.
  - If it is empty, the shift register takes all zeros and tx_underrun pulses.
  - The bit counter is cleared.
- SHIFT, on each detected SCLK rise:
  - RX shift register takes {rx[DATA_WIDTH-2:0], MOSI_sync}.
  - TX shift register shifts left by one.
  - The counter increments.
  - At count DATA_WIDTH: RDATA takes the assembled byte, rx_data_valid pulses, and the next LOAD starts the next byte without a gap.
- MISO = TX shift MSB while sel=1, else 0. Each MISO bit changes once, a few clk cycles after the SCLK rise on which the master samples the previous bit. This gives almost a full SCLK period of setup before the next rise.
- Holding register: a load is accepted only when `apb_ready` && RDY. A strobe while RDY=0 is ignored and the register contents are unchanged.
- Same-cycle load and LOAD with the register empty: no bypass. The new byte goes to the holding register, the frame shifts 0x00, and tx_underrun pulses.
- SSbar rises mid-byte: the partial byte is discarded with no rx_data_valid. RDATA and the holding register are untouched, the counter clears, and MISO and MISO_oe drop.
- Detected SCLK edges while sel=0 are ignored.
- rst_n low mid-frame: all state returns to reset values immediately. A frame already in progress on the pins is ignored until the next SSbar fall.

## Timing
- Pin-to-detect latency: SYNC_STAGES+1 clk cycles for SCLK and SSbar edges.
- First MISO bit is valid SYNC_STAGES+2 cycles after SSbar falls. The master must leave at least SYNC_STAGES+3 clk cycles between the SSbar fall and the first SCLK rise.
- SCLK high and low phases must each be at least 2 clk cycles. The default master setting of clk/4 meets this.
- rx_data_valid asserts SYNC_STAGES+1 cycles after the last SCLK rise reaches the pin. It stays high for exactly one cycle.
- RDY returns to 1 in the cycle after LOAD consumes the holding register.
- Back-to-back frames with SSbar held low: the next MSB is on MISO before the next SCLK rise as long as the master keeps its normal bit period.

## Test plan
- Reset: hold rst_n=0 → every output at its reset value, RDY=1. Release and issue a load of 0x5A → RDY=0 in the next cycle.
- Single frame: load 0xAA, master sends 0x3C at clk/4 → master samples 1,0,1,0,1,0,1,0. RDATA=0x3C with one rx_data_valid pulse, RDY returns to 1.
- Continuous frames: load 0xA5, then 0x0F after RDY rises, SSbar held low for 16 bits, master sends 0x11 and 0x22 → MISO carries 0xA5 then 0x0F. Two rx_data_valid pulses with RDATA 0x11 then 0x22.
- Underrun and ignored load: start a frame with the register empty → tx_underrun pulses and MISO returns 0x00. A second strobe while RDY=0 leaves the first loaded byte intact.
- Abort: raise SSbar after 5 bits → no rx_data_valid and RDATA unchanged. The next full frame receives correctly from bit 0.
- Reset mid-frame: drop rst_n after 3 bits → outputs reset immediately and the rest of that frame is ignored. The next frame is received correctly.
